load_types_unit: RTL and testbench
==================================

Name: load_types_unit

Overview:
- Load-path counterpart of the store formatter in the MEM stage.
- Accepts one load request (opcode and byte address) and runs a word read on the data-memory port with a ready handshake.
- Selects the addressed byte or halfword lane, then sign- or zero-extends it to 32 bits.
- Returns a registered result with a one-cycle valid pulse, and flags misaligned or timed-out accesses.

Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT_CYCLES, 15, maximum cycles in WAIT_MEM before the access is aborted with a bus error; must be ≥1.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instruccion  in  6  opcode: LB=100000, LH=100001, LW=100011, LBU=100100, LHU=100101.
- addr  in  ADDR_W  byte address of the load.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready && the opcode is a load.
- mem_rd_en  out  1  read strobe to data memory; held high in WAIT_MEM.
- mem_addr  out  ADDR_W  word-aligned address: latched addr with bits [1:0] forced to 0.
- mem_rdata  in  32  memory read data; valid when mem_ready=1.
- mem_ready  in  1  memory read completes this cycle.
- data_out  out  32  extended load result.
- out_valid  out  1  one-cycle pulse when data_out and the error flags are new.
- misaligned  out  1  result came from a misaligned request (MISALIGN_TRAP_EN only; otherwise tied 0).
- bus_err  out  1  result came from a timeout.

Behaviour:
- Reset (async assert, synchronous release): state=IDLE, timeout counter=0, all outputs 0 (req_ready becomes 1 once in IDLE). Reset mid-access abandons the access and drops mem_rd_en immediately.
- State IDLE:
  - A non-load opcode with req_valid is ignored; no state change.
  - On acceptance, latch opcode and addr[1:0]. Go to WAIT_MEM, or to DONE with misaligned=1 when a trap applies (see Optional Feature).
- State WAIT_MEM:
  - mem_rd_en=1; the counter increments each cycle.
  - mem_ready=1: capture the formatted mem_rdata into data_out, set bus_err=0 and misaligned=0, then go to DONE. mem_ready wins if it coincides with the final timeout cycle.
  - Counter reaches TIMEOUT_CYCLES without mem_ready: data_out=0, bus_err=1, go to DONE.
- State DONE: out_valid=1 for exactly one cycle, then IDLE. data_out and the flags hold until the next result.
- Latency: with a zero-wait memory, acceptance at cycle N gives mem_rd_en at N+1 and out_valid at N+2. Throughput is one load per 3 cycles minimum.
- Lane mapping is little-endian: offset 0 → bits [7:0]; halfword offset 0 → [15:0], offset 2 → [31:16].
- Extension:
  - LB, LH replicate the selected sign bit (bit 7 or bit 15) through bit 31.
  - LBU, LHU zero-fill the upper bits.
  - LW passes the word unchanged.
- No back-pressure on the output; the consumer must sample on out_valid.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: LH/LHU with addr[0]=1, or LW with addr[1:0]≠0, skips memory and goes IDLE→DONE with data_out=0 and misaligned=1.
- Undefined: no check. For halfwords, addr[0] is ignored and lane = addr[1]. For LW, offset bits are ignored. The misaligned port is tied 0.

Decomposition:
- Package load_pkg:
  - opcode constants OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU;
  - state encoding IDLE/WAIT_MEM/DONE;
  - a function that classifies an opcode as a load.
- One combinational sub-module, load_extend: inputs are opcode, offset and the 32-bit word; output is the 32-bit extended result. It is reused by the top and by the bench reference model.

Test Plan:
- LB at addr 0x103, mem_rdata=0x80FF1234, zero-wait memory → data_out=0xFFFFFF80, out_valid at cycle N+2.
- LBU at addr 0x103, same data → data_out=0x00000080.
- LH at 0x102 and LHU at 0x100 on mem_rdata=0x9ABC7F01 → 0xFFFF9ABC and 0x00007F01 respectively; mem_addr=0x100 in both cases.
- LW at 0x200, mem_ready withheld for TIMEOUT_CYCLES → bus_err=1, data_out=0, one-cycle out_valid. Repeat with mem_ready on the final cycle → bus_err=0 and correct data.
- Reset asserted during WAIT_MEM → mem_rd_en=0 and req_ready=0 asynchronously; after release, req_ready=1 and no out_valid appears.
- With MISALIGN_TRAP_EN, LW at 0x101 → mem_rd_en never asserted, misaligned=1 and out_valid at N+1. Without the macro, the same request reads 0x100 and returns the full word.

Source files
------------

// File: rtl/load_types_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : load_pkg                                                       |
// | Purpose : Shared definitions for the load path of the MEM stage:         |
// |           load opcodes, controller state encoding and opcode helpers.    |
// | Optional: MISALIGN_TRAP_EN (consumer of is_misaligned)                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package load_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_MEM = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  // Halfwords must sit on an even byte, words on a multiple of four.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
    return (((op == OP_LH) || (op == OP_LHU)) && off[0]) ||
           ((op == OP_LW) && (off != 2'b00));
  endfunction

endpackage : load_pkg
`default_nettype wire

// File: rtl/load_types_unit_extend.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : load_extend                                                    |
// | Purpose : Combinational lane select and sign/zero extension of a         |
// |           32-bit memory word for LB/LH/LW/LBU/LHU.                       |
// | Ports   : i_opcode [5:0]  load opcode                                    |
// |           i_offset [1:0]  byte offset within the word                    |
// |           i_word   [31:0] raw word from memory                           |
// |           o_result [31:0] extended load result                           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module load_extend
  import load_pkg::*;
(
  input  logic [5:0]  i_opcode,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_word,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Little-endian lanes; the halfword lane ignores offset bit 0.
  always_comb begin
    w_byte = i_word[7:0];
    case (i_offset)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_result = i_word;
    case (i_opcode)
      OP_LB:   o_result = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_result = {24'd0, w_byte};
      OP_LH:   o_result = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_result = {16'd0, w_half};
      default: o_result = i_word;
    endcase
  end

endmodule : load_extend
`default_nettype wire

// File: rtl/load_types_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : load_types_unit                                                |
// | Purpose : MEM-stage load formatter. Accepts one load request, performs   |
// |           a word read with a ready handshake (bounded by a timeout),     |
// |           extends the addressed lane and returns a registered result     |
// |           with a one-cycle valid pulse.                                  |
// | Optional: MISALIGN_TRAP_EN - trap misaligned LH/LHU/LW without touching  |
// |           memory; when undefined, misaligned is tied low.                |
// | Ports   : clk, rst_n (async assert, active low)                          |
// |           instruccion/addr/req_valid/req_ready  request handshake        |
// |           mem_rd_en/mem_addr/mem_rdata/mem_ready memory read port        |
// |           data_out/out_valid/misaligned/bus_err  result                  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module load_types_unit
  import load_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        instruccion,
  input  logic [ADDR_W-1:0] addr,
  input  logic              req_valid,
  output logic              req_ready,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       data_out,
  output logic              out_valid,
  output logic              misaligned,
  output logic              bus_err
);

  // One extra count value so the counter can step past the last wait cycle.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [5:0]        r_op;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req_ready;
  logic [31:0]       r_data;
  logic              r_bus_err;
  logic              w_accept;
  logic              w_trap;
  logic              w_timeout;
  logic [31:0]       w_ext;

  assign w_accept  = req_valid && r_req_ready && is_load(instruccion);
  // Last permitted wait cycle; a coincident mem_ready still takes priority.
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MISALIGN_TRAP_EN
  assign w_trap = is_misaligned(instruccion, addr[1:0]);
`else
  assign w_trap = 1'b0;
`endif

  load_extend u_extend (
    .i_opcode (r_op),
    .i_offset (r_off),
    .i_word   (mem_rdata),
    .o_result (w_ext)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = w_trap ? ST_DONE : ST_WAIT_MEM;
      end
      ST_WAIT_MEM: begin
        if (mem_ready || w_timeout) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= 6'd0;
      r_off       <= 2'd0;
      r_mem_addr  <= '0;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_data      <= 32'd0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Registered so ready is low throughout reset and rises one cycle after release.
      r_req_ready <= (w_state_nxt == ST_IDLE);
      if (w_accept) begin
        r_op       <= instruccion;
        r_off      <= addr[1:0];
        r_mem_addr <= {addr[ADDR_W-1:2], 2'b00};
        r_cnt      <= '0;
        if (w_trap) begin
          r_data    <= 32'd0;
          r_bus_err <= 1'b0;
        end
      end
      if (r_state == ST_WAIT_MEM) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (mem_ready) begin
          r_data    <= w_ext;
          r_bus_err <= 1'b0;
        end else if (w_timeout) begin
          r_data    <= 32'd0;
          r_bus_err <= 1'b1;
        end
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic r_misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misaligned <= 1'b0;
    end else if (w_accept) begin
      r_misaligned <= w_trap;
    end
  end

  assign misaligned = r_misaligned;
`else
  assign misaligned = 1'b0;
`endif

  assign req_ready = r_req_ready;
  assign mem_rd_en = (r_state == ST_WAIT_MEM);
  assign mem_addr  = r_mem_addr;
  assign data_out  = r_data;
  assign out_valid = (r_state == ST_DONE);
  assign bus_err   = r_bus_err;

endmodule : load_types_unit
`default_nettype wire

// File: tb/tb_load_types_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_load_types_unit                                             |
// | Purpose : Self-checking bench for load_types_unit: directed loads,       |
// |           timeout boundaries, reset mid-access, ignored opcodes and      |
// |           randomized loads against a behavioural reference model.        |
// | Optional: MISALIGN_TRAP_EN selects trap expectations.                    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_load_types_unit;
  import load_pkg::*;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  instruccion = 6'd0;
  logic [31:0] addr = 32'd0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;
  logic [31:0] data_out;
  logic        out_valid;
  logic        misaligned;
  logic        bus_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_types_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruccion (instruccion),
    .addr        (addr),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .misaligned  (misaligned),
    .bus_err     (bus_err)
  );

  // Reference: shift the word so the addressed lane lands at bit 0, then extend.
  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    int          sv;
    b = 8'(w >> (8 * int'(a[1:0])));
    h = 16'(w >> (16 * int'(a[1])));
    case (op)
      OP_LB:   begin sv = $signed(b); return sv; end
      OP_LH:   begin sv = $signed(h); return sv; end
      OP_LBU:  return {24'd0, b};
      OP_LHU:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic ref_trap(input logic [5:0] op, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    if ((op == OP_LH || op == OP_LHU) && a[0]) return 1'b1;
    if (op == OP_LW && (a % 4) != 0) return 1'b1;
`else
    if (op == 6'h3f && a == 32'hffff_ffff) return 1'b0;
`endif
    return 1'b0;
  endfunction

  // Runs one load starting at a negedge in IDLE; mem_ready is raised in the
  // (wait_c+1)-th wait cycle, or never if wait_c >= TO.
  task automatic do_load(input logic [5:0] op, input logic [31:0] a, input logic [31:0] word,
                         input int wait_c, input logic [31:0] exp_word, input string tag);
    logic        trap;
    logic        tmo;
    logic [31:0] exp_d;
    bit          done;
    trap  = ref_trap(op, a);
    tmo   = !trap && (wait_c >= TO);
    exp_d = (trap || tmo) ? 32'd0 : exp_word;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL %s req_ready: got %b want 1", tag, req_ready);
    end
    instruccion = op; addr = a; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; instruccion = 6'($urandom); addr = $urandom;
    if (!trap) begin
      done = 0;
      for (int k = 1; k <= TO && !done; k++) begin
        n_vec++;
        if ({mem_rd_en, mem_addr, out_valid} !== {1'b1, a & 32'hffff_fffc, 1'b0}) begin
          n_err++;
          $display("FAIL %s wait%0d rd_en/addr/valid: got %b/%h/%b want 1/%h/0",
                   tag, k, mem_rd_en, mem_addr, out_valid, a & 32'hffff_fffc);
        end
        if (k == wait_c + 1) begin mem_ready = 1'b1; mem_rdata = word; done = 1; end
        else begin mem_ready = 1'b0; mem_rdata = $urandom; end
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = $urandom;
      end
    end
    n_vec++;
    if ({out_valid, mem_rd_en} !== 2'b10) begin
      n_err++; $display("FAIL %s done valid/rd_en: got %b/%b want 1/0", tag, out_valid, mem_rd_en);
    end
    n_vec++;
    if (data_out !== exp_d) begin
      n_err++; $display("FAIL %s data_out: got %h want %h", tag, data_out, exp_d);
    end
    n_vec++;
    if ({bus_err, misaligned} !== {tmo, trap}) begin
      n_err++; $display("FAIL %s bus_err/misaligned: got %b/%b want %b/%b",
                        tag, bus_err, misaligned, tmo, trap);
    end
    @(negedge clk);
    n_vec++;
    if ({out_valid, req_ready, data_out} !== {1'b0, 1'b1, exp_d}) begin
      n_err++; $display("FAIL %s after pulse valid/ready/data: got %b/%b/%h want 0/1/%h",
                        tag, out_valid, req_ready, data_out, exp_d);
    end
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if ({req_ready, mem_rd_en, mem_addr, data_out, out_valid, misaligned, bus_err} !== '0) begin
      n_err++; $display("FAIL reset outputs: got %b/%b/%h/%h/%b/%b/%b want all 0",
                        req_ready, mem_rd_en, mem_addr, data_out, out_valid, misaligned, bus_err);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL reset release req_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_directed();
    do_load(OP_LB,  32'h103, 32'h80FF1234, 0, 32'hFFFFFF80, "lb_103");
    do_load(OP_LBU, 32'h103, 32'h80FF1234, 0, 32'h00000080, "lbu_103");
    do_load(OP_LH,  32'h102, 32'h9ABC7F01, 0, 32'hFFFF9ABC, "lh_102");
    do_load(OP_LHU, 32'h100, 32'h9ABC7F01, 0, 32'h00007F01, "lhu_100");
    do_load(OP_LW,  32'h101, 32'hDEADBEEF, 0, 32'hDEADBEEF, "lw_101");
    do_load(OP_LHU, 32'h103, 32'h9ABC7F01, 2, 32'h00009ABC, "lhu_103");
  endtask

  task automatic test_timeout();
    do_load(OP_LW, 32'h200, 32'h13579BDF, TO,     32'h0,        "lw_timeout");
    do_load(OP_LW, 32'h200, 32'h13579BDF, TO - 1, 32'h13579BDF, "lw_last_cycle");
  endtask

  task automatic test_ignore_nonload();
    logic [5:0] bad [4] = '{6'b000000, 6'b101011, 6'b100010, 6'b100110};
    for (int i = 0; i < 4; i++) begin
      instruccion = bad[i]; addr = $urandom; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      n_vec++;
      if ({req_ready, mem_rd_en, out_valid} !== 3'b100) begin
        n_err++; $display("FAIL nonload %b ready/rd_en/valid: got %b/%b/%b want 1/0/0",
                          bad[i], req_ready, mem_rd_en, out_valid);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    instruccion = OP_LW; addr = 32'h340; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({mem_rd_en, req_ready, out_valid} !== 3'b000) begin
      n_err++; $display("FAIL reset_mid rd_en/ready/valid: got %b/%b/%b want 0/0/0",
                        mem_rd_en, req_ready, out_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if ({req_ready, mem_rd_en, out_valid, data_out} !== {3'b100, 32'd0}) begin
        n_err++; $display("FAIL reset_mid after release ready/rd_en/valid/data: got %b/%b/%b/%h want 1/0/0/0",
                          req_ready, mem_rd_en, out_valid, data_out);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0]  ops [5] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] w;
    int          wt;
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 4)];
      a  = $urandom;
      w  = $urandom;
      wt = ($urandom_range(0, 7) == 0) ? TO : int'($urandom_range(0, 3));
      do_load(op, a, w, wt, ref_load(op, a, w), $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_ignore_nonload();
    @(negedge clk);
    test_reset_mid_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_load_types_unit
`default_nettype wire
